// File: rtl/ram_port_arbiter.sv
// Two-requester scheduler for a one-read/one-write-port block RAM.
// Packs up to one read and one write per cycle and never issues a same-address pair.
module ram_port_arbiter #(
  parameter  int WIDTH = 64,
  parameter  int SIZE  = 512,
  localparam int ABITS = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  input  logic             r0_we,
  input  logic [ABITS-1:0] r0_addr,
  input  logic [WIDTH-1:0] r0_wdata,
  output logic             r0_ready,
  input  logic             r1_valid,
  input  logic             r1_we,
  input  logic [ABITS-1:0] r1_addr,
  input  logic [WIDTH-1:0] r1_wdata,
  output logic             r1_ready,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             ram_rden,
  output logic [ABITS-1:0] ram_rdaddr,
  input  logic [WIDTH-1:0] ram_rddata,
  output logic             ram_wren,
  output logic [ABITS-1:0] ram_wraddr,
  output logic [WIDTH-1:0] ram_wrdata
);

  logic             rd0, rd1, wr0, wr1;
  logic             pre_rd0, pre_rd1, pre_wr0, pre_wr1;
  logic             gnt_rd0, gnt_rd1, gnt_wr0, gnt_wr1;
  logic             rd_any, wr_any, conflict, same_type;
  logic [ABITS-1:0] rd_addr, wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             prio_q, wr_starved_q;
  logic [1:0]       rd_owner_q;

  // NOTE: every signal gets a default at the top so no path can leave one unassigned (no latch).
  always_comb begin
    rd0 = r0_valid & ~r0_we;
    rd1 = r1_valid & ~r1_we;
    wr0 = r0_valid &  r0_we;
    wr1 = r1_valid &  r1_we;

    pre_rd0 = rd0 & (~rd1 | ~prio_q);
    pre_rd1 = rd1 & (~rd0 |  prio_q);
    pre_wr0 = wr0 & (~wr1 | ~prio_q);
    pre_wr1 = wr1 & (~wr0 |  prio_q);

    rd_addr = pre_rd1 ? r1_addr : r0_addr;
    wr_addr = pre_wr1 ? r1_addr : r0_addr;
    wr_data = pre_wr1 ? r1_wdata : r0_wdata;

    // A reader and a writer together are always one of each requester.
    conflict  = (pre_rd0 | pre_rd1) & (pre_wr0 | pre_wr1) & (rd_addr == wr_addr);
    same_type = (rd0 & rd1) | (wr0 & wr1);

    gnt_rd0 = pre_rd0;
    gnt_rd1 = pre_rd1;
    gnt_wr0 = pre_wr0;
    gnt_wr1 = pre_wr1;
    if (conflict) begin
      if (wr_starved_q) begin
        gnt_rd0 = 1'b0;
        gnt_rd1 = 1'b0;
      end else begin
        gnt_wr0 = 1'b0;
        gnt_wr1 = 1'b0;
      end
    end
    if (rst) begin
      gnt_rd0 = 1'b0;
      gnt_rd1 = 1'b0;
      gnt_wr0 = 1'b0;
      gnt_wr1 = 1'b0;
    end

    rd_any   = gnt_rd0 | gnt_rd1;
    wr_any   = gnt_wr0 | gnt_wr1;
    r0_ready = gnt_rd0 | gnt_wr0;
    r1_ready = gnt_rd1 | gnt_wr1;
  end

  assign rsp_data = ram_rddata;

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q       <= 1'b0;
      wr_starved_q <= 1'b0;
      ram_rden     <= 1'b0;
      ram_rdaddr   <= '0;
      ram_wren     <= 1'b0;
      ram_wraddr   <= '0;
      ram_wrdata   <= '0;
      rd_owner_q   <= '0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
    end else begin
      if (same_type) prio_q <= ~prio_q;
      if (wr_any)        wr_starved_q <= 1'b0;
      else if (conflict) wr_starved_q <= 1'b1;

      ram_rden <= rd_any;
      if (rd_any) ram_rdaddr <= rd_addr;
      ram_wren <= wr_any;
      if (wr_any) begin
        ram_wraddr <= wr_addr;
        ram_wrdata <= wr_data;
      end

      // Owner tag travels with the read so the response lands on the right requester.
      rd_owner_q <= {gnt_rd1, gnt_rd0};
      rsp0_valid <= rd_owner_q[0];
      rsp1_valid <= rd_owner_q[1];
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: table-driven grants plus a read-response scoreboard
// against a behavioural read-priority block RAM.
module tb_ram_port_arbiter;

  localparam int WIDTH = 64;
  localparam int SIZE  = 512;
  localparam int ABITS = $clog2(SIZE);

  logic             clk = 1'b0;
  logic             rst;
  logic             r0_valid, r0_we, r1_valid, r1_we;
  logic [ABITS-1:0] r0_addr, r1_addr;
  logic [WIDTH-1:0] r0_wdata, r1_wdata;
  logic             r0_ready, r1_ready, rsp0_valid, rsp1_valid;
  logic [WIDTH-1:0] rsp_data, ram_rddata, ram_wrdata;
  logic             ram_rden, ram_wren;
  logic [ABITS-1:0] ram_rdaddr, ram_wraddr;

  ram_port_arbiter #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_ready(r1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .ram_rden(ram_rden), .ram_rdaddr(ram_rdaddr), .ram_rddata(ram_rddata),
    .ram_wren(ram_wren), .ram_wraddr(ram_wraddr), .ram_wrdata(ram_wrdata)
  );

  always #5 clk = ~clk;

  // Block RAM model: registered read, and a same-address write loses to the read.
  logic [WIDTH-1:0] mem [SIZE];
  always @(posedge clk) begin
    if (ram_rden) ram_rddata <= mem[ram_rdaddr];
    if (ram_wren && !(ram_rden && ram_rdaddr == ram_wraddr)) mem[ram_wraddr] <= ram_wrdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]       owner;
    logic [WIDTH-1:0] data;
    int               when;
  } rsp_t;
  rsp_t sb[$];

  typedef struct {
    logic v0, we0; int a0; logic [WIDTH-1:0] d0;
    logic v1, we1; int a1; logic [WIDTH-1:0] d1;
    logic e0, e1;
  } vec_t;

  function automatic vec_t mk(input logic v0, we0, input int a0, input logic [WIDTH-1:0] d0,
                              input logic v1, we1, input int a1, input logic [WIDTH-1:0] d1,
                              input logic e0, e1);
    vec_t v;
    v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  logic [WIDTH-1:0] ref_mem [SIZE];
  logic             exp_rden = 1'b0, exp_wren = 1'b0;
  logic [ABITS-1:0] exp_rdaddr = '0, exp_wraddr = '0;
  logic [WIDTH-1:0] exp_wrdata = '0;

  // Response monitor: every pulse must match the oldest expected read, in its cycle.
  always @(negedge clk) begin
    check("rsp_exclusive", rsp0_valid & rsp1_valid, 1'b0);
    check("no_same_addr_pair", ram_rden && ram_wren && (ram_rdaddr == ram_wraddr), 1'b0);
    if (rsp0_valid || rsp1_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        check("rsp_owner", {rsp1_valid, rsp0_valid}, e.owner);
        check("rsp_data", rsp_data, e.data);
        check("rsp_cycle", cyc, e.when);
      end
    end else if (sb.size() != 0 && sb[0].when < cyc) begin
      check("missing_rsp_cycle", cyc, sb[0].when);
      void'(sb.pop_front());
    end
  end

  task automatic apply(input vec_t v);
    logic g_rd0, g_rd1, g_wr0, g_wr1;
    @(negedge clk);
    r0_valid = v.v0; r0_we = v.we0; r0_addr = ABITS'(v.a0); r0_wdata = v.d0;
    r1_valid = v.v1; r1_we = v.we1; r1_addr = ABITS'(v.a1); r1_wdata = v.d1;
    #2;
    check("ram_rden", ram_rden, exp_rden);
    if (exp_rden) check("ram_rdaddr", ram_rdaddr, exp_rdaddr);
    check("ram_wren", ram_wren, exp_wren);
    if (exp_wren) begin
      check("ram_wraddr", ram_wraddr, exp_wraddr);
      check("ram_wrdata", ram_wrdata, exp_wrdata);
    end
    check("r0_ready", r0_ready, v.e0);
    check("r1_ready", r1_ready, v.e1);
    g_rd0 = v.v0 && !v.we0 && v.e0;
    g_rd1 = v.v1 && !v.we1 && v.e1;
    g_wr0 = v.v0 &&  v.we0 && v.e0;
    g_wr1 = v.v1 &&  v.we1 && v.e1;
    exp_rden   = g_rd0 || g_rd1;
    exp_rdaddr = ABITS'(g_rd1 ? v.a1 : v.a0);
    exp_wren   = g_wr0 || g_wr1;
    exp_wraddr = ABITS'(g_wr1 ? v.a1 : v.a0);
    exp_wrdata = g_wr1 ? v.d1 : v.d0;
    if (g_rd0) sb.push_back('{2'b01, ref_mem[v.a0], cyc + 2});
    if (g_rd1) sb.push_back('{2'b10, ref_mem[v.a1], cyc + 2});
    if (g_wr0) ref_mem[v.a0] = v.d0;
    if (g_wr1) ref_mem[v.a1] = v.d1;
  endtask

  vec_t tbl[$];
  vec_t idle;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < SIZE; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    idle = mk(0,0,0,0, 0,0,0,0, 0,0);

    // single ops
    tbl.push_back(mk(1,1,5,64'hDEAD, 0,0,0,0,       1,0));
    tbl.push_back(mk(1,0,5,0,        0,0,0,0,       1,0));
    tbl.push_back(idle);
    tbl.push_back(idle);
    // write contention, prio 0 then prio 1
    tbl.push_back(mk(1,1,1,64'h111,  1,1,2,64'h222, 1,0));
    tbl.push_back(mk(0,0,0,0,        1,1,2,64'h222, 0,1));
    tbl.push_back(mk(1,1,8,64'h888,  1,1,9,64'h999, 0,1));
    tbl.push_back(mk(1,1,8,64'h888,  0,0,0,0,       1,0));
    // read contention, six cycles, alternating grants
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(1,0,1,0, 1,0,2,0, (i % 2) == 0, (i % 2) == 1));
    // parallel read and write, then read the write back
    tbl.push_back(mk(1,0,3,0,        1,1,4,64'h44,  1,1));
    tbl.push_back(mk(1,0,4,0,        1,0,9,0,       1,0));
    tbl.push_back(mk(0,0,0,0,        1,0,9,0,       0,1));
    // same-address conflict, reader on r0
    tbl.push_back(mk(1,1,7,64'h11,   0,0,0,0,       1,0));
    tbl.push_back(mk(1,0,7,0,        1,1,7,64'h22,  1,0));
    tbl.push_back(mk(1,0,7,0,        1,1,7,64'h22,  0,1));
    tbl.push_back(mk(1,0,7,0,        0,0,0,0,       1,0));
    // same-address conflict, reader on r1
    tbl.push_back(mk(1,1,8,64'h1234, 1,0,8,0,       0,1));
    tbl.push_back(mk(1,1,8,64'h1234, 1,0,8,0,       1,0));
    tbl.push_back(mk(0,0,0,0,        1,0,8,0,       0,1));
    for (int i = 0; i < 4; i++) tbl.push_back(idle);

    // reset with a read pending: ready must stay low
    rst = 1'b1;
    r0_valid = 1'b1; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_valid = 1'b1; r1_we = 1'b1; r1_addr = '0; r1_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_r0_ready", r0_ready, 1'b0);
    check("rst_r1_ready", r1_ready, 1'b0);
    check("rst_ram_rden", ram_rden, 1'b0);
    check("rst_ram_wren", ram_wren, 1'b0);
    check("rst_ram_rdaddr", ram_rdaddr, '0);
    check("rst_ram_wraddr", ram_wraddr, '0);
    check("rst_ram_wrdata", ram_wrdata, '0);
    check("rst_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
    rst = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // reset mid-flight: the accepted read must never respond
    apply(mk(1,0,1,0, 0,0,0,0, 1,0));
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("midrst_ready", r0_ready, 1'b0);
    check("midrst_inflight_rden", ram_rden, 1'b1);
    @(negedge clk);
    #2;
    check("midrst_ram_rden", ram_rden, 1'b0);
    check("midrst_ram_wren", ram_wren, 1'b0);
    check("midrst_rdaddr", ram_rdaddr, '0);
    check("midrst_rsp0", rsp0_valid, 1'b0);
    rst = 1'b0;
    r0_valid = 1'b0;
    exp_rden = 1'b0;
    exp_wren = 1'b0;
    apply(idle);
    apply(mk(1,0,1,0, 1,0,2,0, 1,0));
    apply(mk(0,0,0,0, 1,0,2,0, 0,1));
    for (int i = 0; i < 4; i++) apply(idle);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
